// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor update path.
//   bht_ctr_t          2-bit saturating BHT counter
//   CTR_RESET          value written to every entry by the initialisation sweep
//   bht_sched_state_t  update scheduler FSM states
//   sat_inc / sat_dec  saturating counter training steps
package bp_pkg;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_RESET = 2'b01;

  typedef enum logic {INIT, RUN} bht_sched_state_t;

  function automatic bht_ctr_t sat_inc(input bht_ctr_t c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic bht_ctr_t sat_dec(input bht_ctr_t c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Small synchronous FIFO holding pending BHT training updates ({idx, ctr}).
//   clk_i, reset_n_i  clock and asynchronous active-low reset
//   clear_i           synchronous flush of all entries
//   push_i, wdata_i   enqueue; accepted when not full, or when full with a same-cycle pop
//   pop_i             dequeue the head (ignored when empty)
//   rdata_o           head entry (valid when ~empty_o)
//   full_o, empty_o   occupancy flags
module bht_upd_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 2
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot the push lands in, so a full queue still accepts.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (clear_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/bht_update_scheduler.sv
// Sequences all writes into the BHT of 2-bit counters: an initialisation sweep after reset or
// flush, then execute-stage training updates queued onto the single write port.
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   flush_req_i               restart the initialisation sweep
//   stall_e_i, branch_op_e_i  execute stage qualifiers (op bit0 = conditional branch)
//   pc_src_res_e_i            resolved outcome (1 = taken)
//   upd_idx_e_i, upd_ctr_e_i  index and counter value captured at prediction time
//   bht_we_o/waddr_o/wdata_o  registered BHT write port
//   pred_valid_o, busy_o      table initialised / sweep in progress
//   drop_cnt_o                saturating count of updates lost to a full queue
module bht_update_scheduler
  import bp_pkg::*;
#(
  parameter int unsigned IDX_WIDTH = 8,
  parameter int unsigned QDEPTH    = 2,
  parameter int unsigned DROP_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 flush_req_i,
  input  logic                 stall_e_i,
  input  logic [1:0]           branch_op_e_i,
  input  logic                 pc_src_res_e_i,
  input  logic [IDX_WIDTH-1:0] upd_idx_e_i,
  input  logic [1:0]           upd_ctr_e_i,
  output logic                 bht_we_o,
  output logic [IDX_WIDTH-1:0] bht_waddr_o,
  output logic [1:0]           bht_wdata_o,
  output logic                 pred_valid_o,
  output logic                 busy_o,
  output logic [DROP_W-1:0]    drop_cnt_o
);

  bht_sched_state_t     state_q, state_d;
  logic [IDX_WIDTH-1:0] sweep_ptr_q, sweep_ptr_d;
  logic                 we_q, we_d;
  logic [IDX_WIDTH-1:0] addr_q, addr_d;
  bht_ctr_t             data_q, data_d;
  logic [DROP_W-1:0]    drop_q, drop_d;

  logic                 upd_acc;
  bht_ctr_t             upd_ctr_new;
  logic                 fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  logic [IDX_WIDTH-1:0] head_idx;
  bht_ctr_t             head_ctr;

  assign upd_acc     = branch_op_e_i[0] & ~stall_e_i & ~flush_req_i;
  assign upd_ctr_new = pc_src_res_e_i ? sat_inc(upd_ctr_e_i) : sat_dec(upd_ctr_e_i);

  bht_upd_fifo #(
    .Width (IDX_WIDTH + 2),
    .Depth (QDEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (fifo_clear),
    .push_i    (fifo_push),
    .wdata_i   ({upd_idx_e_i, upd_ctr_new}),
    .pop_i     (fifo_pop),
    .rdata_o   ({head_idx, head_ctr}),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    sweep_ptr_d = sweep_ptr_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    drop_d      = drop_q;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_clear  = 1'b0;

    if (flush_req_i) begin
      // Same-cycle updates are already excluded from upd_acc; they are not drops.
      state_d     = INIT;
      sweep_ptr_d = '0;
      fifo_clear  = 1'b1;
    end else begin
      unique case (state_q)
        INIT: begin
          we_d        = 1'b1;
          addr_d      = sweep_ptr_q;
          data_d      = CTR_RESET;
          sweep_ptr_d = sweep_ptr_q + IDX_WIDTH'(1);
          if (sweep_ptr_q == '1) state_d = RUN;
          if (upd_acc) begin
            if (!fifo_full)        fifo_push = 1'b1;
            else if (drop_q != '1) drop_d    = drop_q + DROP_W'(1);
          end
        end
        RUN: begin
          if (!fifo_empty) begin
            we_d      = 1'b1;
            addr_d    = head_idx;
            data_d    = head_ctr;
            fifo_pop  = 1'b1;
            fifo_push = upd_acc;
          end else if (upd_acc) begin
            we_d   = 1'b1;
            addr_d = upd_idx_e_i;
            data_d = upd_ctr_new;
          end
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= INIT;
      sweep_ptr_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      sweep_ptr_q <= sweep_ptr_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      drop_q      <= drop_d;
    end
  end

  assign bht_we_o     = we_q;
  assign bht_waddr_o  = addr_q;
  assign bht_wdata_o  = data_q;
  assign pred_valid_o = (state_q == RUN);
  assign busy_o       = (state_q == INIT);
  assign drop_cnt_o   = drop_q;

endmodule
